// File: rtl/nmi_arbiter.sv
// N-master to 1-slave arbiter for the native memory interface (round-robin or fixed priority).
// Optional slave-response timeout is enabled by defining NMI_ARB_TIMEOUT_EN.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | no grant; picks a winner from m_valid_i and registers it
// ST_BUSY | granted master routed to the slave until ready/abort/timeout
module nmi_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic [NUM_MASTERS-1:0]              m_valid_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_addr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_wdata_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_wstrb_i,
    output logic [NUM_MASTERS-1:0]              m_ready_o,
    output logic [DATA_WIDTH-1:0]               m_rdata_o,
    output logic                                s_valid_o,
    output logic [ADDR_WIDTH-1:0]               s_addr_o,
    output logic [DATA_WIDTH-1:0]               s_wdata_o,
    output logic [DATA_WIDTH/8-1:0]             s_wstrb_o,
    input  logic                                s_ready_i,
    input  logic [DATA_WIDTH-1:0]               s_rdata_i,
    output logic [NUM_MASTERS-1:0]              gnt_o,
    output logic                                busy_o,
    output logic                                err_o
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    if (NUM_MASTERS < 1 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1 || ARB_MODE < 0 || ARB_MODE > 1)
    begin : g_bad_param
        $error("nmi_arbiter: unsupported parameter value");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [IDX_W-1:0]         r_gnt_idx;
    logic [IDX_W-1:0]         w_gnt_idx_nxt;
    logic [IDX_W-1:0]         r_last_gnt;
    logic [IDX_W-1:0]         w_last_gnt_nxt;
    logic [NUM_MASTERS-1:0]   r_gnt_oh;
    logic [NUM_MASTERS-1:0]   w_gnt_oh_nxt;

    logic [IDX_W-1:0]         w_win_idx;
    logic [NUM_MASTERS-1:0]   w_win_oh;
    int                       w_cand;

    logic [ADDR_WIDTH-1:0]    w_sel_addr;
    logic [DATA_WIDTH-1:0]    w_sel_wdata;
    logic [STRB_WIDTH-1:0]    w_sel_wstrb;
    logic                     w_gnt_valid;
    logic                     w_timeout;

    // Winner search; the last assignment in each loop has the highest priority.
    always_comb begin
        w_win_idx = '0;
        w_cand    = 0;
        if (ARB_MODE == 1) begin
            for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
                if (m_valid_i[k]) begin
                    w_win_idx = IDX_W'(k);
                end
            end
        end else begin
            for (int k = NUM_MASTERS; k >= 1; k--) begin
                w_cand = (int'(r_last_gnt) + k) % NUM_MASTERS;
                if (m_valid_i[w_cand]) begin
                    w_win_idx = IDX_W'(w_cand);
                end
            end
        end
    end

    always_comb begin
        w_win_oh = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_win_oh[k] = (w_win_idx == IDX_W'(k));
        end
    end

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_wstrb = '0;
        w_gnt_valid = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (r_gnt_idx == IDX_W'(k)) begin
                w_sel_addr  = m_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = m_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
                w_sel_wstrb = m_wstrb_i[k*STRB_WIDTH +: STRB_WIDTH];
                w_gnt_valid = m_valid_i[k];
            end
        end
    end

`ifdef NMI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_to_cnt;

    // Counts BUSY cycles without a slave response; held at zero outside BUSY.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_to_cnt <= '0;
        end else if (r_state != ST_BUSY) begin
            r_to_cnt <= '0;
        end else if (!s_ready_i && !w_timeout) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == ST_BUSY) && (r_to_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            r_gnt_idx  <= '0;
            r_gnt_oh   <= '0;
            r_last_gnt <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            r_state    <= w_state_nxt;
            r_gnt_idx  <= w_gnt_idx_nxt;
            r_gnt_oh   <= w_gnt_oh_nxt;
            r_last_gnt <= w_last_gnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_idx_nxt  = r_gnt_idx;
        w_gnt_oh_nxt   = r_gnt_oh;
        w_last_gnt_nxt = r_last_gnt;
        m_ready_o      = '0;
        m_rdata_o      = '0;
        s_valid_o      = 1'b0;
        s_addr_o       = '0;
        s_wdata_o      = '0;
        s_wstrb_o      = '0;
        err_o          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (|m_valid_i) begin
                    w_gnt_idx_nxt = w_win_idx;
                    w_gnt_oh_nxt  = w_win_oh;
                    w_state_nxt   = ST_BUSY;
                end
            end

            ST_BUSY: begin
                s_valid_o = 1'b1;
                s_addr_o  = w_sel_addr;
                s_wdata_o = w_sel_wdata;
                s_wstrb_o = w_sel_wstrb;
                // Timeout wins over a coincident late response; ready wins over a valid drop.
                if (w_timeout) begin
                    s_valid_o      = 1'b0;
                    m_ready_o      = r_gnt_oh;
                    m_rdata_o      = '1;
                    err_o          = 1'b1;
                    w_last_gnt_nxt = r_gnt_idx;
                    w_gnt_oh_nxt   = '0;
                    w_state_nxt    = ST_IDLE;
                end else if (s_ready_i) begin
                    m_ready_o      = r_gnt_oh;
                    m_rdata_o      = s_rdata_i;
                    w_last_gnt_nxt = r_gnt_idx;
                    w_gnt_oh_nxt   = '0;
                    w_state_nxt    = ST_IDLE;
                end else if (!w_gnt_valid) begin
                    w_gnt_oh_nxt = '0;
                    w_state_nxt  = ST_IDLE;
                end
            end

            default: begin
                w_gnt_oh_nxt = '0;
                w_state_nxt  = ST_IDLE;
            end
        endcase
    end

    assign gnt_o  = r_gnt_oh;
    assign busy_o = (r_state == ST_BUSY);

endmodule

// File: doc/nmi_arbiter.md
Name: nmi_arbiter

Overview:
- Parametrised N-master to 1-slave arbiter on the native memory interface (NMI: valid/ready/addr/wdata/wstrb/rdata).
- Lets several user cores, or a core plus a DMA, share one NMI port into the SoC crossbar.
- Supports round-robin or fixed-priority arbitration.
- Holds the grant for a full transaction and adds one arbitration cycle per transfer.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (1..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- TIMEOUT_CYCLES, 256, slave-response timeout limit; used only with NMI_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous active-low reset
- m_valid_i  in  NUM_MASTERS  per-master request
- m_addr_i  in  NUM_MASTERS*ADDR_WIDTH  packed addresses, master k at slice k
- m_wdata_i  in  NUM_MASTERS*DATA_WIDTH  packed write data
- m_wstrb_i  in  NUM_MASTERS*DATA_WIDTH/8  packed strobes; all zero means read
- m_ready_o  out  NUM_MASTERS  per-master completion pulse
- m_rdata_o  out  DATA_WIDTH  read data, shared; valid only with the m_ready_o pulse
- s_valid_o  out  1  slave request
- s_addr_o  out  ADDR_WIDTH  slave address
- s_wdata_o  out  DATA_WIDTH  slave write data
- s_wstrb_o  out  DATA_WIDTH/8  slave strobes
- s_ready_i  in  1  slave completion
- s_rdata_i  in  DATA_WIDTH  slave read data
- gnt_o  out  NUM_MASTERS  one-hot current grant, 0 when idle
- busy_o  out  1  high in BUSY state
- err_o  out  1  timeout pulse (tied 0 without the macro)

Behaviour:
- Clock and reset: one clock domain, clk_i. rst_n_i is synchronous, active-low.
- Reset values:
  - state = IDLE.
  - gnt_o, m_ready_o, s_valid_o, busy_o, err_o = 0.
  - s_addr_o, s_wdata_o, s_wstrb_o, m_rdata_o = 0.
  - Round-robin last-grant pointer = NUM_MASTERS-1, so master 0 wins first.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - If any m_valid_i bit is set, select a winner and register its index into gnt and gnt_o, then go to BUSY.
  - s_valid_o stays 0 during this cycle, so request-to-s_valid latency is exactly 1 cycle.
- Winner selection:
  - ARB_MODE=0: first set bit searching upward from last_grant+1, with modulo NUM_MASTERS wrap.
  - ARB_MODE=1: lowest set index.
- BUSY, routing:
  - s_valid_o = 1.
  - s_addr_o, s_wdata_o and s_wstrb_o are combinationally muxed from the granted master's slices.
  - Non-granted masters see m_ready_o = 0.
- BUSY, completion (s_ready_i = 1):
  - m_ready_o[gnt] = 1 combinationally in the same cycle.
  - m_rdata_o = s_rdata_i in the same cycle.
  - last_grant <= gnt, then go to IDLE.
  - Minimum spacing is 2 cycles per transfer. No back-to-back grant: IDLE always inserts one cycle.
- BUSY, abort (m_valid_i[gnt] deasserts before s_ready_i):
  - Protocol violation. Return to IDLE next cycle without pulsing m_ready_o.
  - last_grant is unchanged.
- Simultaneous s_ready_i and valid drop in the same cycle: counts as completion.
- Requests arriving during BUSY are held off, with ready low. Masters must keep valid and payload stable until ready.
- NUM_MASTERS = 1: degenerate case. Same 1-cycle arbitration; gnt_o = 1 while busy.
- Reset asserted mid-transaction: immediate return to reset values at the next edge. The in-flight transfer is dropped and no ready pulse is generated.
- Round-robin fairness: with all masters requesting continuously, each master gets exactly one grant per NUM_MASTERS transfers.

Optional Feature:
- Macro NMI_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to BUSY and increments each BUSY cycle without s_ready_i.
  - On reaching TIMEOUT_CYCLES, the arbiter completes the transfer locally:
    - m_ready_o[gnt] = 1.
    - m_rdata_o = all-ones (32'hFFFF_FFFF at default width).
    - err_o = 1, a single-cycle pulse.
    - s_valid_o drops; go to IDLE; last_grant updates.
  - A late s_ready_i arriving in IDLE is ignored.
- Undefined: no counter; err_o is tied 0; BUSY waits indefinitely.

Test Plan:
- Single read, NUM_MASTERS=2: m_valid_i=01, addr 0x3000_0000, slave ready 3 cycles after s_valid_o with rdata 0x1234_5678 -> s_valid_o rises 1 cycle after request; m_ready_o=01 for one cycle with m_rdata_o=0x1234_5678; gnt_o returns to 0.
- Round-robin contention, NUM_MASTERS=3, ARB_MODE=0: all three masters request continuously, slave ready after 1 cycle -> grant order 0,1,2,0,1,2; each transfer takes 2 cycles minimum.
- Fixed priority, ARB_MODE=1: masters 1 and 2 request continuously -> master 1 always wins; master 2 is granted only after master 1 drops valid.
- Write routing: master 1 sends wstrb=0101, wdata 0xAABB_CCDD, addr 0x1000_0004 -> s_wstrb_o, s_wdata_o and s_addr_o match exactly; master 0 sees no ready.
- Abort and reset: granted master drops valid in BUSY -> no m_ready_o, IDLE next cycle. Reset asserted mid-BUSY -> all outputs 0 at the next edge, and the next grant goes to master 0.
- With NMI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: slave never asserts ready -> after 8 BUSY cycles, m_ready_o pulses, rdata=0xFFFF_FFFF and err_o pulses once; a late s_ready_i is ignored.
